// File: rtl/slot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | slot_pkg : shared types and win codes for the slot-machine spin controller |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package slot_pkg;

    localparam int SYM_W     = 3;
    localparam int NUM_REELS = 3;
    localparam int WIN_W     = 2;

    localparam logic [WIN_W-1:0] WIN_NONE   = 2'd0;
    localparam logic [WIN_W-1:0] WIN_PAIR   = 2'd1;
    localparam logic [WIN_W-1:0] WIN_TRIPLE = 2'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPIN3 = 3'd1,
        SPIN2 = 3'd2,
        SPIN1 = 3'd3,
        EVAL  = 3'd4
    } state_t;

    function automatic logic [WIN_W-1:0] win_code(
        input logic [SYM_W-1:0] a,
        input logic [SYM_W-1:0] b,
        input logic [SYM_W-1:0] c
    );
        if (a == b && b == c)
            return WIN_TRIPLE;
        else if (a == b || b == c || a == c)
            return WIN_PAIR;
        else
            return WIN_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slot_spin_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | slot_spin_ctrl : three-reel spin sequencer with staggered stops and payout |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module slot_spin_ctrl
    import slot_pkg::*;
#(
    parameter int unsigned SPIN_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 25_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spin,
    input  logic              pause,
    input  logic [15:0]       rand_in,
    output logic              rng_en,
    output logic [SYM_W-1:0]  reel0,
    output logic [SYM_W-1:0]  reel1,
    output logic [SYM_W-1:0]  reel2,
    output logic              busy,
    output logic              done,
    output logic [WIN_W-1:0]  win
);

    localparam logic [31:0] c_SPIN_LOAD = 32'(SPIN_CYCLES - 1);
    localparam logic [31:0] c_GAP_LOAD  = 32'(GAP_CYCLES - 1);

    state_t             state_q, state_d;
    logic [31:0]        timer_q, timer_d;
    logic               spin_q;
    logic               rng_en_q;
    logic [SYM_W-1:0]   reel0_q, reel0_d;
    logic [SYM_W-1:0]   reel1_q, reel1_d;
    logic [SYM_W-1:0]   reel2_q, reel2_d;
    logic [WIN_W-1:0]   win_q, win_d;

    logic               w_edge;
    logic               w_tmo;
    logic               w_unused_rand;

    assign w_edge        = spin & ~spin_q;
    assign w_tmo         = (timer_q == 32'd0);
    assign w_unused_rand = ^{rand_in[15:13], rand_in[9:8], rand_in[4:3]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= 32'd0;
            spin_q   <= 1'b0;
            rng_en_q <= 1'b0;
            reel0_q  <= '0;
            reel1_q  <= '0;
            reel2_q  <= '0;
            win_q    <= WIN_NONE;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            spin_q   <= spin;
            rng_en_q <= ~pause;
            reel0_q  <= reel0_d;
            reel1_q  <= reel1_d;
            reel2_q  <= reel2_d;
            win_q    <= win_d;
        end
    end

    // Every spinning reel tracks the generator; a reel "stops" simply by no longer loading.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        reel0_d = reel0_q;
        reel1_d = reel1_q;
        reel2_d = reel2_q;
        win_d   = win_q;
        unique case (state_q)
            IDLE: begin
                if (w_edge && !pause) begin
                    state_d = SPIN3;
                    timer_d = c_SPIN_LOAD;
                    win_d   = WIN_NONE;
                end
            end
            SPIN3: begin
                if (!pause) begin
                    reel0_d = rand_in[2:0];
                    reel1_d = rand_in[7:5];
                    reel2_d = rand_in[12:10];
                    timer_d = w_tmo ? c_GAP_LOAD : timer_q - 32'd1;
                    if (w_tmo) state_d = SPIN2;
                end
            end
            SPIN2: begin
                if (!pause) begin
                    reel1_d = rand_in[7:5];
                    reel2_d = rand_in[12:10];
                    timer_d = w_tmo ? c_GAP_LOAD : timer_q - 32'd1;
                    if (w_tmo) state_d = SPIN1;
                end
            end
            SPIN1: begin
                if (!pause) begin
                    reel2_d = rand_in[12:10];
                    timer_d = w_tmo ? 32'd0 : timer_q - 32'd1;
                    if (w_tmo) state_d = EVAL;
                end
            end
            EVAL: begin
                win_d   = win_code(reel0_q, reel1_q, reel2_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == EVAL);
    assign rng_en = rng_en_q;
    assign reel0  = reel0_q;
    assign reel1  = reel1_q;
    assign reel2  = reel2_q;
    assign win    = win_q;

endmodule
`default_nettype wire

// File: tb/tb_slot_spin_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_slot_spin_ctrl : directed and randomized checks against a game model    |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module tb_slot_spin_ctrl;

    localparam int S        = 4;
    localparam int G        = 2;
    localparam int GAME_LEN = S + 2 * G + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        spin;
    logic        pause;
    logic [15:0] rand_in;
    logic        rng_en;
    logic [2:0]  reel0, reel1, reel2;
    logic        busy;
    logic        done;
    logic [1:0]  win;

    int n_total = 0;
    int n_pass  = 0;

    // Game-level model: m_k counts unpaused spinning cycles of the current game.
    bit          m_busy;
    int          m_k;
    logic [2:0]  m_reel [3];
    logic [1:0]  m_win;
    logic        m_spin_prev;
    logic        m_rng;

    always #5 clk = ~clk;

    slot_spin_ctrl #(
        .SPIN_CYCLES (S),
        .GAP_CYCLES  (G)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .spin    (spin),
        .pause   (pause),
        .rand_in (rand_in),
        .rng_en  (rng_en),
        .reel0   (reel0),
        .reel1   (reel1),
        .reel2   (reel2),
        .busy    (busy),
        .done    (done),
        .win     (win)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_k = 0;
        for (int i = 0; i < 3; i++) m_reel[i] = 3'd0;
        m_win = 2'd0;
        m_spin_prev = 1'b0;
        m_rng = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic p, input logic [15:0] r);
        if (m_busy) begin
            if (m_k == S + 2 * G) begin
                if (m_reel[0] == m_reel[1] && m_reel[1] == m_reel[2]) m_win = 2'd2;
                else if (m_reel[0] == m_reel[1] || m_reel[1] == m_reel[2] ||
                         m_reel[0] == m_reel[2]) m_win = 2'd1;
                else m_win = 2'd0;
                m_busy = 0;
            end else if (!p) begin
                m_k++;
                for (int i = 0; i < 3; i++)
                    if (m_k <= S + i * G) m_reel[i] = r[5*i +: 3];
            end
        end else if (s && !m_spin_prev && !p) begin
            m_busy = 1;
            m_k = 0;
            m_win = 2'd0;
        end
        m_spin_prev = s;
        m_rng = !p;
    endtask

    task automatic check_all();
        chk("busy",   32'(busy),   32'(m_busy));
        chk("done",   32'(done),   32'(m_busy && m_k == S + 2 * G));
        chk("reel0",  32'(reel0),  32'(m_reel[0]));
        chk("reel1",  32'(reel1),  32'(m_reel[1]));
        chk("reel2",  32'(reel2),  32'(m_reel[2]));
        chk("win",    32'(win),    32'(m_win));
        chk("rng_en", 32'(rng_en), 32'(m_rng));
    endtask

    task automatic step(input logic s, input logic p, input logic [15:0] r);
        @(negedge clk);
        spin = s;
        pause = p;
        rand_in = r;
        @(posedge clk);
        model_step(s, p, r);
        #1;
        check_all();
    endtask

    // Reset is checked a fraction after assertion, before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_reels", 32'({reel0, reel1, reel2}), 32'd0);
        check_all();
        @(negedge clk);
        spin = 1'b0;
        rst = 1'b0;
    endtask

    task automatic play(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input int pause_at, input int pause_len, input bit toggle,
                        input int post_hold, input int exp_len, input logic [1:0] exp_win,
                        input logic [2:0] e0, input logic [2:0] e1, input logic [2:0] e2,
                        input string name);
        int busy_n = 0, done_n = 0, act = 0, paused = 0, cyc = 0, restarts = 0;
        logic [15:0] r;
        logic p, s;
        step(1'b0, 1'b0, 16'($urandom));
        step(1'b1, 1'b0, 16'($urandom));
        if (busy) busy_n++;
        while (busy && cyc < 60) begin
            p = (pause_at > 0 && busy_n >= pause_at && paused < pause_len);
            r = 16'($urandom);
            if (!p) begin
                act++;
                if (act == S)         r = a;
                if (act == S + G)     r = b;
                if (act == S + 2 * G) r = c;
            end
            s = !(toggle && act == S + G + 1);
            step(s, p, r);
            if (p) paused++;
            if (busy) busy_n++;
            if (done) done_n++;
            cyc++;
        end
        for (int i = 0; i < post_hold; i++) begin
            step(1'b1, 1'b0, 16'($urandom));
            if (busy) restarts++;
        end
        chk({name, "_len"},     32'(busy_n),   32'(exp_len));
        chk({name, "_done"},    32'(done_n),   32'd1);
        chk({name, "_reels"},   32'({reel0, reel1, reel2}), 32'({e0, e1, e2}));
        chk({name, "_win"},     32'(win),      32'(exp_win));
        chk({name, "_restart"}, 32'(restarts), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        spin = 1'b0;
        pause = 1'b0;
        rand_in = 16'h0;
        model_reset();
        do_reset();

        play(16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, GAME_LEN, 2'd2, 3'd0, 3'd0, 3'd0, "zeros");
        play(16'h0001, 16'h0001, 16'h0400, 0, 0, 0, 0, GAME_LEN, 2'd1, 3'd1, 3'd0, 3'd1, "b0_only");
        play(16'h0001, 16'h0020, 16'h0400, 0, 0, 0, 0, GAME_LEN, 2'd2, 3'd1, 3'd1, 3'd1, "ones");
        play(16'h0001, 16'h0020, 16'h0002, 0, 0, 0, 0, GAME_LEN, 2'd1, 3'd1, 3'd1, 3'd0, "pair");
        play(16'h0001, 16'h0040, 16'h0C00, 0, 0, 0, 0, GAME_LEN, 2'd0, 3'd1, 3'd2, 3'd3, "none");
        play(16'h0007, 16'h00E0, 16'h1C00, 5, 5, 0, 0, GAME_LEN + 5, 2'd2, 3'd7, 3'd7, 3'd7, "pause");
        play(16'h0005, 16'h00A0, 16'h0400, 0, 0, 1, 20, GAME_LEN, 2'd1, 3'd5, 3'd5, 3'd1, "hold");

        step(1'b0, 1'b0, 16'($urandom));
        step(1'b1, 1'b0, 16'h1CE7);
        step(1'b1, 1'b0, 16'h1CE7);
        step(1'b1, 1'b0, 16'h1CE7);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        do_reset();
        play(16'h0003, 16'h0060, 16'h0C00, 0, 0, 0, 0, GAME_LEN, 2'd2, 3'd3, 3'd3, 3'd3, "after_rst");

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                spin = 1'($urandom_range(0, 1));
                do_reset();
            end else begin
                step(($urandom_range(0, 4) == 0) ? ~spin : spin,
                     ($urandom_range(0, 7) == 0),
                     16'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
